// File: rtl/pit_bus_master_if.sv
// Request/response handshake and 8254-style bus signals for pit_bus_master.
// The master modport is the initiator's view; slave is the host/PIT side.
interface pit_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a0;
  logic       a1;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, data_in,
    output req_ready, resp_valid, resp_rdata,
    output cs_n, rd_n, wr_n, a0, a1, data_out, data_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, data_in,
    input  req_ready, resp_valid, resp_rdata,
    input  cs_n, rd_n, wr_n, a0, a1, data_out, data_oe
  );
endinterface

// File: rtl/pit_bus_master.sv
// Host-side initiator turning valid/ready requests into timed 8254 bus cycles
// (SETUP -> STROBE -> HOLD), with every bus output driven straight from a flop.
module pit_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input logic               clk,
  input logic               rst_n,
  pit_bus_master_if.master  bus
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_param_check
    $error("pit_bus_master: SETUP_CYC/STROBE_CYC/HOLD_CYC must be in 1..15");
  end

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] phase_r, phase_s;
  logic       write_r, write_s;
  logic [1:0] addr_r, addr_s;
  logic [7:0] data_out_r, data_out_s;
  logic [7:0] resp_rdata_r, resp_rdata_s;
  logic       resp_valid_r, resp_valid_s;
  logic       req_ready_r, req_ready_s;
  logic       cs_n_r, cs_n_s;
  logic       rd_n_r, rd_n_s;
  logic       wr_n_r, wr_n_s;
  logic       data_oe_r, data_oe_s;

  // Next state, latched request fields, and the bus outputs decoded from the next state.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    write_s      = write_r;
    addr_s       = addr_r;
    data_out_s   = data_out_r;
    resp_rdata_s = resp_rdata_r;
    resp_valid_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.req_valid && req_ready_r) begin
          state_s = SETUP;
          phase_s = 4'd0;
          write_s = bus.req_write;
          addr_s  = bus.req_addr;
          if (bus.req_write) begin
            data_out_s = bus.req_wdata;
          end else begin
            data_out_s = data_out_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (phase_r == SETUP_LAST) begin
          state_s = STROBE;
          phase_s = 4'd0;
        end else begin
          phase_s = phase_r + 4'd1;
        end
      end
      STROBE: begin
        if (phase_r == STROBE_LAST) begin
          state_s = HOLD;
          phase_s = 4'd0;
          // Read data is captured while rd_n is still low, on the edge that raises it.
          if (!write_r) begin
            resp_rdata_s = bus.data_in;
          end else begin
            resp_rdata_s = resp_rdata_r;
          end
        end else begin
          phase_s = phase_r + 4'd1;
        end
      end
      HOLD: begin
        if (phase_r == HOLD_LAST) begin
          state_s      = IDLE;
          phase_s      = 4'd0;
          resp_valid_s = 1'b1;
        end else begin
          phase_s = phase_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        phase_s = 4'd0;
      end
    endcase

    req_ready_s = (state_s == IDLE);
    cs_n_s      = (state_s == IDLE);
    rd_n_s      = !((state_s == STROBE) && !write_s);
    wr_n_s      = !((state_s == STROBE) && write_s);
    data_oe_s   = (state_s != IDLE) && write_s;
  end

  // State and output registers; reset forces the idle bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      phase_r      <= 4'd0;
      write_r      <= 1'b0;
      addr_r       <= 2'd0;
      data_out_r   <= 8'h00;
      resp_rdata_r <= 8'h00;
      resp_valid_r <= 1'b0;
      req_ready_r  <= 1'b1;
      cs_n_r       <= 1'b1;
      rd_n_r       <= 1'b1;
      wr_n_r       <= 1'b1;
      data_oe_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      write_r      <= write_s;
      addr_r       <= addr_s;
      data_out_r   <= data_out_s;
      resp_rdata_r <= resp_rdata_s;
      resp_valid_r <= resp_valid_s;
      req_ready_r  <= req_ready_s;
      cs_n_r       <= cs_n_s;
      rd_n_r       <= rd_n_s;
      wr_n_r       <= wr_n_s;
      data_oe_r    <= data_oe_s;
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.cs_n       = cs_n_r;
  assign bus.rd_n       = rd_n_r;
  assign bus.wr_n       = wr_n_r;
  assign bus.a1         = addr_r[1];
  assign bus.a0         = addr_r[0];
  assign bus.data_out   = data_out_r;
  assign bus.data_oe    = data_oe_r;

endmodule

// File: tb/tb_pit_bus_master.sv
// Self-checking bench for pit_bus_master: default-timing DUT plus a long-timing DUT,
// with response and bus-write scoreboards for the default instance.
module tb_pit_bus_master;

  typedef struct packed {
    logic       is_read;
    logic [7:0] rdata;
  } resp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] rd_value_a;
  resp_t      exp_resp_q[$];
  logic [9:0] exp_wr_q[$];
  logic       prev_wr_n;

  pit_bus_master_if bus_a ();
  pit_bus_master_if bus_b ();

  pit_bus_master dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  pit_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Minimal PIT read model: the register value appears only while the read strobe is active.
  assign bus_a.data_in = (!bus_a.cs_n && !bus_a.rd_n) ? rd_value_a : 8'h00;
  assign bus_b.data_in = (!bus_b.cs_n && !bus_b.rd_n) ? 8'hC3 : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for DUT A: pops expected responses and expected bus writes as they appear.
  always @(negedge clk) begin
    if (bus_a.resp_valid === 1'b1) begin
      checks++;
      if (exp_resp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got resp_valid=1 rdata=%h, required no response", bus_a.resp_rdata);
      end else begin
        resp_t e;
        e = exp_resp_q.pop_front();
        if (e.is_read && bus_a.resp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL resp_rdata: got %h, required %h", bus_a.resp_rdata, e.rdata);
        end
      end
    end
    if (prev_wr_n === 1'b1 && bus_a.wr_n === 1'b0) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL bus_write_unexpected: got addr=%0d data=%h, required no write",
                 {bus_a.a1, bus_a.a0}, bus_a.data_out);
      end else begin
        logic [9:0] w;
        w = exp_wr_q.pop_front();
        if ({bus_a.a1, bus_a.a0, bus_a.data_out} !== w) begin
          errors++;
          $display("FAIL bus_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   {bus_a.a1, bus_a.a0}, bus_a.data_out, w[9:8], w[7:0]);
        end
      end
    end
    prev_wr_n <= bus_a.wr_n;
  end

  task automatic drive_a(input logic valid, input logic wr, input logic [1:0] addr, input logic [7:0] wdata);
    bus_a.req_valid = valid;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    bus_b.req_valid = 1'b0;
    bus_b.req_write = 1'b0;
    bus_b.req_addr  = 2'd0;
    bus_b.req_wdata = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.cs_n, bus_a.rd_n, bus_a.wr_n, bus_a.a1, bus_a.a0, bus_a.data_oe, bus_a.req_ready, bus_a.resp_valid} !== 8'b1110_0010) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b, required 11100010",
               {bus_a.cs_n, bus_a.rd_n, bus_a.wr_n, bus_a.a1, bus_a.a0, bus_a.data_oe, bus_a.req_ready, bus_a.resp_valid});
    end
    checks++;
    if ({bus_a.data_out, bus_a.resp_rdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data_a: got data_out=%h resp_rdata=%h, required 00 00", bus_a.data_out, bus_a.resp_rdata);
    end
    checks++;
    if ({bus_b.cs_n, bus_b.rd_n, bus_b.wr_n, bus_b.data_oe, bus_b.req_ready, bus_b.resp_valid} !== 6'b111010) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b, required 111010",
               {bus_b.cs_n, bus_b.rd_n, bus_b.wr_n, bus_b.data_oe, bus_b.req_ready, bus_b.resp_valid});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_ctrl();
    logic [4:0] exp_v;
    logic [4:0] got_v;
    exp_wr_q.push_back({2'd3, 8'h34});
    exp_resp_q.push_back('{1'b0, 8'h00});
    drive_a(1'b1, 1'b1, 2'd3, 8'h34);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus_a.req_valid = 1'b0;
      exp_v = {1'(c == 5), 1'(c == 5), 1'b1, !(c == 2 || c == 3), 1'(c == 5)};
      got_v = {bus_a.req_ready, bus_a.cs_n, bus_a.rd_n, bus_a.wr_n, bus_a.resp_valid};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL write_ctrl_c%0d: got ready/cs_n/rd_n/wr_n/resp=%b, required %b", c, got_v, exp_v);
      end
      if (c <= 4) begin
        checks++;
        if ({bus_a.a1, bus_a.a0, bus_a.data_oe, bus_a.data_out} !== {3'b111, 8'h34}) begin
          errors++;
          $display("FAIL write_data_c%0d: got a1a0oe=%b data=%h, required 111 34", c,
                   {bus_a.a1, bus_a.a0, bus_a.data_oe}, bus_a.data_out);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [3:0] exp_v;
    logic [3:0] got_v;
    rd_value_a = 8'hA5;
    exp_resp_q.push_back('{1'b1, 8'hA5});
    drive_a(1'b1, 1'b0, 2'd1, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus_a.req_valid = 1'b0;
      exp_v = {1'(c == 5), !(c == 2 || c == 3), 1'b1, 1'(c == 5)};
      got_v = {bus_a.cs_n, bus_a.rd_n, bus_a.wr_n, bus_a.resp_valid};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL read_ctrl_c%0d: got cs_n/rd_n/wr_n/resp=%b, required %b", c, got_v, exp_v);
      end
      if (c <= 4) begin
        checks++;
        if ({bus_a.a1, bus_a.a0, bus_a.data_oe} !== 3'b010) begin
          errors++;
          $display("FAIL read_addr_c%0d: got a1a0oe=%b, required 010", c, {bus_a.a1, bus_a.a0, bus_a.data_oe});
        end
      end else begin
        checks++;
        if (bus_a.resp_rdata !== 8'hA5) begin
          errors++;
          $display("FAIL read_rdata: got %h, required a5", bus_a.resp_rdata);
        end
      end
    end
    rd_value_a = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] addrs [3];
    logic [7:0] datas [3];
    int         accept_cyc [3];
    int         idx;
    int         hi_run;
    logic       prev_cs;
    addrs = '{2'd3, 2'd0, 2'd0};
    datas = '{8'h34, 8'h10, 8'h27};
    accept_cyc = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      exp_wr_q.push_back({addrs[i], datas[i]});
      exp_resp_q.push_back('{1'b0, 8'h00});
    end
    idx = 0;
    hi_run = 0;
    prev_cs = 1'b1;
    drive_a(1'b1, 1'b1, addrs[0], datas[0]);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (prev_cs && !bus_a.cs_n) begin
        if (idx < 3) accept_cyc[idx] = c;
        if (idx >= 1) begin
          checks++;
          if (hi_run != 1) begin
            errors++;
            $display("FAIL b2b_cs_gap: got cs_n high for %0d cycles, required 1", hi_run);
          end
        end
        idx++;
        if (idx < 3) drive_a(1'b1, 1'b1, addrs[idx], datas[idx]);
        else bus_a.req_valid = 1'b0;
      end
      if (bus_a.cs_n) hi_run++;
      else hi_run = 0;
      prev_cs = bus_a.cs_n;
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d transactions, required 3", idx);
    end
    checks++;
    if ((accept_cyc[1] - accept_cyc[0]) != 5 || (accept_cyc[2] - accept_cyc[1]) != 5) begin
      errors++;
      $display("FAIL b2b_period: got intervals %0d and %0d, required 5 and 5",
               accept_cyc[1] - accept_cyc[0], accept_cyc[2] - accept_cyc[1]);
    end
    bus_a.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    logic [2:0] exp_v;
    logic [2:0] got_v;
    rd_value_a = 8'h5C;
    exp_resp_q.push_back('{1'b1, 8'h5C});
    drive_a(1'b1, 1'b0, 2'd2, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus_a.req_valid = 1'b0;
      if (c == 2) drive_a(1'b1, 1'b1, 2'd0, 8'hFF);
      if (c == 3) bus_a.req_valid = 1'b0;
      exp_v = {!(c >= 1 && c <= 4), !(c == 2 || c == 3), 1'b1};
      got_v = {bus_a.cs_n, bus_a.rd_n, bus_a.wr_n};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL ignore_busy_c%0d: got cs_n/rd_n/wr_n=%b, required %b", c, got_v, exp_v);
      end
    end
    rd_value_a = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_v;
    logic [2:0] got_v;
    exp_wr_q.push_back({2'd0, 8'h77});
    drive_a(1'b1, 1'b1, 2'd0, 8'h77);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.wr_n !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_strobe: got wr_n=%b, required 0", bus_a.wr_n);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.cs_n, bus_a.wr_n, bus_a.rd_n, bus_a.data_oe, bus_a.req_ready} !== 5'b11101) begin
      errors++;
      $display("FAIL rstmid_async: got cs_n/wr_n/rd_n/oe/ready=%b, required 11101",
               {bus_a.cs_n, bus_a.wr_n, bus_a.rd_n, bus_a.data_oe, bus_a.req_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus_a.resp_valid !== 1'b0 || bus_a.cs_n !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_quiet_c%0d: got resp_valid=%b cs_n=%b, required 0 1", c, bus_a.resp_valid, bus_a.cs_n);
      end
    end
    exp_wr_q.push_back({2'd2, 8'h99});
    exp_resp_q.push_back('{1'b0, 8'h00});
    drive_a(1'b1, 1'b1, 2'd2, 8'h99);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus_a.req_valid = 1'b0;
      exp_v = {1'(c == 5), !(c == 2 || c == 3), 1'(c == 5)};
      got_v = {bus_a.cs_n, bus_a.wr_n, bus_a.resp_valid};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rstmid_after_c%0d: got cs_n/wr_n/resp=%b, required %b", c, got_v, exp_v);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_long_timing();
    resp_t exp_b_q[$];
    int    cs_low;
    int    rd_low;
    int    resp_cyc;
    cs_low = 0;
    rd_low = 0;
    resp_cyc = 0;
    exp_b_q.push_back('{1'b1, 8'hC3});
    bus_b.req_valid = 1'b1;
    bus_b.req_write = 1'b0;
    bus_b.req_addr  = 2'd0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) bus_b.req_valid = 1'b0;
      if (!bus_b.cs_n) cs_low++;
      if (!bus_b.rd_n) begin
        rd_low++;
        checks++;
        if (c < 4 || c > 7) begin
          errors++;
          $display("FAIL long_rd_window: got rd_n low in cycle %0d, required cycles 4..7", c);
        end
      end
      if (bus_b.resp_valid) begin
        resp_cyc = c;
        checks++;
        if (exp_b_q.size() == 0) begin
          errors++;
          $display("FAIL long_resp_extra: got extra resp_valid in cycle %0d, required none", c);
        end else begin
          resp_t e;
          e = exp_b_q.pop_front();
          if (bus_b.resp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL long_rdata: got %h, required %h", bus_b.resp_rdata, e.rdata);
          end
        end
      end
    end
    checks++;
    if (cs_low != 9 || rd_low != 4 || resp_cyc != 10) begin
      errors++;
      $display("FAIL long_timing: got cs_low=%0d rd_low=%0d resp_cycle=%0d, required 9 4 10", cs_low, rd_low, resp_cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_value_a = 8'h00;
    prev_wr_n = 1'b1;
    test_reset();
    test_write_ctrl();
    test_read();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_long_timing();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_resp_q.size() != 0 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d responses and %0d writes outstanding, required 0 0",
               exp_resp_q.size(), exp_wr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pit_bus_master.md
Name: pit_bus_master

Overview:
- Host-side bus initiator that generates Intel 8254-style bus cycles: CS_n, RD_n, WR_n, A1:A0 and data.
- Converts a simple valid/ready request interface into timed read and write strobes for the PIT's register file (counters 0–2, control word).
- Sits between the system controller or test sequencer and the intel8254 top. It lets firmware-like logic program modes and counts, and latch and read back counts.

Parameters:
- SETUP_CYC, 1, clk cycles with cs_n low and address/data stable before the strobe falls (range 1..15).
- STROBE_CYC, 2, clk cycles rd_n/wr_n is held low (range 1..15).
- HOLD_CYC, 1, clk cycles after the strobe rises with cs_n, address and data still held (range 1..15).

Ports:
- clk  input  1  single system clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  host request present.
- req_ready  output  1  block idle and able to accept a request.
- req_write  input  1  1 = write cycle, 0 = read cycle.
- req_addr  input  2  {A1,A0}: 0/1/2 = counter 0/1/2, 3 = control word.
- req_wdata  input  8  write data.
- resp_valid  output  1  one-cycle pulse: transaction complete.
- resp_rdata  output  8  read data, valid with resp_valid on reads; holds its last value otherwise.
- cs_n  output  1  chip select, active low.
- rd_n  output  1  read strobe, active low.
- wr_n  output  1  write strobe, active low.
- a0  output  1  address bit 0.
- a1  output  1  address bit 1.
- data_out  output  8  bus write data.
- data_oe  output  1  1 = drive data_out onto the data bus.
- data_in  input  8  bus read data from the PIT.

Behaviour:
- All bus outputs are registered, so there are no combinational paths from req_* to the bus.
- Reset values (async, immediate):
  - cs_n = rd_n = wr_n = 1; a0 = a1 = 0.
  - data_out = 0x00; data_oe = 0.
  - req_ready = 1; resp_valid = 0; resp_rdata = 0x00.
  - FSM in IDLE; phase counter = 0.
- FSM states: IDLE, SETUP, STROBE, HOLD. A 4-bit phase counter counts cycles within each state.
- IDLE:
  - req_ready = 1; cs_n, rd_n and wr_n high; data_oe = 0.
  - On req_valid & req_ready, latch write, addr and wdata, then go to SETUP.
- SETUP (SETUP_CYC cycles):
  - cs_n = 0; a1/a0 = latched addr.
  - On writes, data_out = latched wdata and data_oe = 1.
  - Strobes stay high. Then go to STROBE.
- STROBE (STROBE_CYC cycles):
  - cs_n = 0; wr_n = 0 (write) or rd_n = 0 (read), never both.
  - For reads, data_in is registered into resp_rdata on the clock edge that ends the last STROBE cycle.
  - Then go to HOLD.
- HOLD (HOLD_CYC cycles):
  - Both strobes high; cs_n, address, data_out and data_oe unchanged.
  - On exit, return to IDLE with resp_valid = 1 for exactly that first IDLE cycle.
- req_ready = 0 in SETUP, STROBE and HOLD. req_valid is ignored there and not queued.
- Back-to-back requests:
  - A request may be accepted in the same IDLE cycle that carries resp_valid.
  - Minimum transaction period is 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles (5 at defaults).
  - cs_n is high for at least one cycle between transactions.
- Address 3 read: the read is issued on the bus anyway (the PIT defines the result); resp_rdata = sampled data_in.
- Reset asserted mid-transaction: outputs return to reset values immediately. The transaction is dropped and no resp_valid is produced. After release the block is in IDLE.
- Phase counter is 4 bits wide; parameter values outside 1..15 are illegal (elaboration check).

Test Plan:
- Reset, then write req_addr=3, req_wdata=0x34 at defaults:
  - req_ready low for 4 cycles.
  - cs_n low for 4 cycles; wr_n low in cycles 2–3 only; a1=a0=1; data_out=0x34 with data_oe=1 throughout.
  - rd_n stays high; resp_valid pulses in cycle 5.
- Read req_addr=1 with data_in=0xA5 during STROBE (0x00 elsewhere):
  - rd_n low for 2 cycles; data_oe=0; a1=0, a0=1.
  - resp_rdata=0xA5 with the resp_valid pulse.
- Three queued writes (0x34 to addr 3, 0x10 then 0x27 to addr 0) with req_valid held high:
  - Accepted every 5 cycles.
  - cs_n high for exactly one cycle between bursts; data order preserved.
- req_valid pulsed during STROBE of an active read:
  - Ignored, with no extra bus cycle.
  - Current read completes normally.
- rst_n dropped in the first STROBE cycle of a write:
  - wr_n and cs_n go high asynchronously; data_oe=0.
  - No resp_valid; the next request after release runs normally.
- SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2 read:
  - cs_n low for 9 cycles; rd_n low for 4.
  - resp_valid 10 cycles after acceptance.
